cpu_seq_ctrl: RTL

- Control FSM for the 8-bit RISC CPU.
- Sequences each two-byte instruction:
  - byte 1: opcode[7:5] plus register address[4:0];
  - byte 2: memory address or operand.
- Drives the instruction register's fetch[1:0] strobe, memory rd/wr, the address mux select, the PC controls, the register file and the ALU.
- Decodes the 3-bit opcode returned by the instruction register.

---
 rtl/cpu_seq_ctrl_pkg.sv | 30 +++
 rtl/cpu_seq_ctrl_mem_wait_cnt.sv | 33 +++
 rtl/cpu_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// cpu_defs: definitions shared by the 8-bit RISC CPU blocks.
// The sequencer, instruction register and ALU use the same opcode values.
// Contents: opcode constants, instruction-register fetch codes and the
// sequencer state encoding.
package cpu_defs;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDR = 3'b001;
   localparam logic [2:0] OP_STR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_JMP = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   localparam logic [1:0] FETCH_HOLD = 2'b00;
   localparam logic [1:0] FETCH_INS  = 2'b01;
   localparam logic [1:0] FETCH_ADR  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH1 = 3'd1,
      ST_FETCH2 = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_PAUSE  = 3'd6
   } state_t;

endpackage

// File: rtl/cpu_seq_ctrl_mem_wait_cnt.sv
// mem_wait_cnt: cycle counter for the memory-access states of the sequencer.
// Counts 0..MEM_WAIT and then holds there until cleared.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   clr   in  restart the count at 0 (pulsed on every state change)
//   last  out count equals MEM_WAIT (final cycle of a memory state)
module mem_wait_cnt #(
   parameter int MEM_WAIT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic last
);

   localparam logic [3:0] LP_WAIT = MEM_WAIT[3:0];

   logic [3:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 4'd0;
      end else if (clr) begin
         r_cnt <= 4'd0;
      end else if (r_cnt != LP_WAIT) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign last = (r_cnt == LP_WAIT);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: control sequencer for the 8-bit RISC CPU.
// Fetches the two-byte instruction (opcode/register byte, then address
// byte), decodes the 3-bit opcode and drives memory, PC, register file
// and ALU strobes. Every memory-touching state lasts MEM_WAIT+1 cycles.
// Optional macro SINGLE_STEP_EN: adds input step and a PAUSE state entered
// instead of FETCH1 after each instruction; step=1 continues.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   start    in   leave IDLE/HALT and begin fetching
//   ins[2:0] in   opcode from the instruction register (valid in FETCH2)
//   step     in   (SINGLE_STEP_EN only) leave PAUSE
//   fetch    out  01 latch opcode byte, 10 latch address byte, 00 hold
//   rd, wr   out  memory read / write
//   mem_sel  out  address mux: 0 = PC, 1 = ad2
//   pc_inc   out  PC += 1          pc_load out PC <= ad2
//   reg_oe   out  register drives bus  reg_we out register write
//   alu_en   out  ALU latches result   halted out FSM in HALT
//
// state   | meaning
// IDLE    | after reset, waiting for start
// FETCH1  | read opcode byte, latch on last cycle
// FETCH2  | read address byte, latch on last cycle, branch on opcode
// EXEC    | execute latched opcode (JMP/LDR/STR/ALU read)
// WB      | write ALU result to register
// HALT    | HLT executed, waiting for start
// PAUSE   | single-step stop between instructions
module cpu_seq_ctrl
   import cpu_defs::*;
#(
   parameter int MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] ins,
`ifdef SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic [1:0] fetch,
   output logic       rd,
   output logic       wr,
   output logic       mem_sel,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       reg_oe,
   output logic       reg_we,
   output logic       alu_en,
   output logic       halted
);

`ifdef SINGLE_STEP_EN
   localparam state_t LP_RESUME = ST_PAUSE;
`else
   localparam state_t LP_RESUME = ST_FETCH1;
`endif

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_op;
   logic       w_last;
   logic       w_clr;

   mem_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .last (w_last)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_HALT: if (start) w_next = ST_FETCH1;
         ST_FETCH1:        if (w_last) w_next = ST_FETCH2;
         ST_FETCH2: begin
            if (w_last) begin
               case (ins)
                  OP_NOP:  w_next = LP_RESUME;
                  OP_HLT:  w_next = ST_HALT;
                  default: w_next = ST_EXEC;
               endcase
            end
         end
         ST_EXEC: begin
            case (r_op)
               OP_JMP:         w_next = LP_RESUME;
               OP_LDR, OP_STR: if (w_last) w_next = LP_RESUME;
               default:        if (w_last) w_next = ST_WB;
            endcase
         end
         ST_WB: w_next = LP_RESUME;
`ifdef SINGLE_STEP_EN
         ST_PAUSE: if (step) w_next = ST_FETCH1;
`endif
         default: w_next = ST_IDLE;
      endcase
   end

   // The wait counter restarts on entry to every state.
   assign w_clr = (w_next != r_state);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_NOP;
      end else begin
         r_state <= w_next;
         // ins is only guaranteed valid in FETCH2; EXEC works from this copy.
         if (r_state == ST_FETCH2 && w_last) r_op <= ins;
      end
   end

   always_comb begin
      fetch   = FETCH_HOLD;
      rd      = 1'b0;
      wr      = 1'b0;
      mem_sel = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      reg_oe  = 1'b0;
      reg_we  = 1'b0;
      alu_en  = 1'b0;
      halted  = 1'b0;
      case (r_state)
         ST_FETCH1: begin
            rd = 1'b1;
            if (w_last) begin
               fetch  = FETCH_INS;
               pc_inc = 1'b1;
            end
         end
         ST_FETCH2: begin
            rd = 1'b1;
            if (w_last) begin
               fetch  = FETCH_ADR;
               pc_inc = 1'b1;
            end
         end
         ST_EXEC: begin
            case (r_op)
               OP_JMP: pc_load = 1'b1;
               OP_STR: begin
                  wr      = 1'b1;
                  mem_sel = 1'b1;
                  reg_oe  = 1'b1;
               end
               OP_LDR: begin
                  rd      = 1'b1;
                  mem_sel = 1'b1;
                  reg_we  = w_last;
               end
               default: begin
                  rd      = 1'b1;
                  mem_sel = 1'b1;
                  alu_en  = w_last;
               end
            endcase
         end
         ST_WB:   reg_we = 1'b1;
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
